// File: rtl/rv64_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// Holds the response-owner tag type carried alongside each in-flight read.
package rv64_mem_pkg;

  localparam int WORD_W     = 64;
  localparam int STRB_W     = 8;
  localparam int RD_LAT_MAX = 4;

  // Owner of the read whose data returns from memory in a given cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } resp_tag_t;

  // Tag to launch for an accepted access; writes never return data
  function automatic resp_tag_t launch_tag(input logic if_win, input logic d_win,
                                           input logic d_write);
    resp_tag_t t;
    t = TAG_NONE;
    if (if_win) begin
      t = TAG_IF;
    end else if (d_win && !d_write) begin
      t = TAG_D;
    end
    return t;
  endfunction

endpackage

// File: rtl/arb_resp_pipe.sv
// Owner-tag delay line matching the memory read latency. The last stage names
// the requester that owns the mem_rdata word present in the current cycle.
module arb_resp_pipe
  import rv64_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_last
);

  resp_tag_t stage [DEPTH];

  // Shift the launch tag toward the return point; reset drops all in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_last = stage[DEPTH-1];

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported 64-bit memory between instruction fetch
// (read-only) and the load/store unit. Data requests win by default; each
// read's owner is tracked so the returned word is registered to the right side.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive denied
// fetch cycles, fetch is forced to win one cycle.
module imem_dmem_arbiter
  import rv64_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_W-1:0]     d_wdata,
  input  logic [STRB_W-1:0]     d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_W-1:0]     d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic [STRB_W-1:0]     mem_wstrb,
  input  logic [WORD_W-1:0]     mem_rdata
);

  // Keep the tag pipe within the supported latency range
  localparam int PIPE_DEPTH = (RD_LAT < 1) ? 1 :
                              (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic      fetch_force;
  resp_tag_t tag_in;
  resp_tag_t tag_last;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  // Count consecutive denied fetch cycles; any grant or dropped request restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= 3'd0;
    end else if (starve_cnt != 3'd7) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign fetch_force = (starve_cnt == 3'(STARVE_MAX));
`else
  assign fetch_force = 1'b0;
`endif

  // Pick at most one winner per cycle; nothing is granted while in reset
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && (!d_req || fetch_force)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Drive the memory port from the winner; idle port is fully zeroed
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
      mem_re   = 1'b1;
    end else if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_we    = 1'b1;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  // Tag launched into the pipe this cycle
  always_comb begin
    tag_in = launch_tag(if_gnt, d_gnt, d_we);
  end

  arb_resp_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (tag_in),
    .tag_last (tag_last)
  );

  // Register returning data to its owner; data holds between valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= (tag_last == TAG_IF);
      d_rvalid  <= (tag_last == TAG_D);
      if (tag_last == TAG_IF) begin
        if_rdata <= mem_rdata;
      end
      if (tag_last == TAG_D) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model (priority rule, a queue of
// expected responses with due cycles, and a copy of memory contents).
module tb_imem_dmem_arbiter;
  import rv64_mem_pkg::*;

  localparam int AW = 4;
  localparam int RL = 1;
  localparam int SM = 4;
  localparam logic [63:0] W1 = 64'h00008067_00100093;
  localparam logic [63:0] W2 = 64'h00200113_003081B3;
  localparam logic [63:0] W3 = 64'h00000013_00418233;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [63:0]   d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0]    d_wstrb, mem_wstrb;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_WIDTH(AW), .RD_LAT(RL), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // Memory environment: command captured mid-cycle, executed at the edge
  logic [63:0]   mem_arr [16];
  logic [63:0]   rd_pipe [RL];
  logic          c_re, c_we;
  logic [AW-1:0] c_addr;
  logic [63:0]   c_wdata;
  logic [7:0]    c_wstrb;

  always @(negedge clk) begin
    c_re = mem_re; c_we = mem_we; c_addr = mem_addr;
    c_wdata = mem_wdata; c_wstrb = mem_wstrb;
  end

  always @(posedge clk) begin
    rd_pipe[0] <= c_re ? mem_arr[c_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (c_we)
      for (int b = 0; b < 8; b++)
        if (c_wstrb[b]) mem_arr[c_addr][8*b +: 8] = c_wdata[8*b +: 8];
  end

  assign mem_rdata = rd_pipe[RL-1];

  // Reference model state
  typedef struct { int due; bit is_if; logic [63:0] data; } resp_t;
  resp_t       pend[$];
  logic [63:0] model_mem [16];
  logic [63:0] exp_if_rdata, exp_d_rdata;
  int          starve_cnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model
  task automatic applyStimulus(input logic r, input logic ireq, input logic [AW-1:0] iaddr,
                               input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                               input logic [63:0] wdata, input logic [7:0] wstrb,
                               output logic ig, output logic dg);
    logic eig, edg, force_f, exp_ifv, exp_dv;
    resp_t rsp;
    rst = r; if_req = ireq; if_addr = iaddr; d_req = dreq; d_we = dwe;
    d_addr = daddr; d_wdata = wdata; d_wstrb = wstrb;
    #3;
    force_f = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_f = (starve_cnt == SM);
`endif
    eig = !r && ireq && (!dreq || force_f);
    edg = !r && dreq && !eig;
    if (r) begin
      pend.delete();
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
    end
    exp_ifv = 1'b0; exp_dv = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rsp = pend.pop_front();
      if (rsp.is_if) begin exp_ifv = 1'b1; exp_if_rdata = rsp.data; end
      else begin exp_dv = 1'b1; exp_d_rdata = rsp.data; end
    end
    checkOutput("if_gnt", 64'(if_gnt), 64'(eig));
    checkOutput("d_gnt", 64'(d_gnt), 64'(edg));
    checkOutput("mem_re", 64'(mem_re), 64'(eig || (edg && !dwe)));
    checkOutput("mem_we", 64'(mem_we), 64'(edg && dwe));
    checkOutput("mem_addr", 64'(mem_addr), eig ? 64'(iaddr) : edg ? 64'(daddr) : 64'd0);
    checkOutput("mem_wstrb", 64'(mem_wstrb), (edg && dwe) ? 64'(wstrb) : 64'd0);
    checkOutput("mem_wdata", mem_wdata, (edg && dwe) ? wdata : 64'd0);
    checkOutput("if_rvalid", 64'(if_rvalid), 64'(exp_ifv));
    checkOutput("d_rvalid", 64'(d_rvalid), 64'(exp_dv));
    checkOutput("if_rdata", if_rdata, exp_if_rdata);
    checkOutput("d_rdata", d_rdata, exp_d_rdata);
    if (eig) pend.push_back('{cyc + RL + 1, 1'b1, model_mem[iaddr]});
    if (edg && !dwe) pend.push_back('{cyc + RL + 1, 1'b0, model_mem[daddr]});
    if (edg && dwe)
      for (int b = 0; b < 8; b++)
        if (wstrb[b]) model_mem[daddr][8*b +: 8] = wdata[8*b +: 8];
    if (r || !ireq || eig) starve_cnt = 0;
    else if (starve_cnt < 7) starve_cnt++;
    ig = eig; dg = edg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ig, dg, fp, dp, dw;
    logic [AW-1:0] fa, da;
    logic [63:0] wd;
    logic [7:0] ws;
    int first_gnt, ngnt;

    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = {32'(i) * 32'h01010101, 32'(i) ^ 32'hA5A5_0000};
      if (i == 1) mem_arr[i] = W1;
      if (i == 2) mem_arr[i] = W2;
      if (i == 3) mem_arr[i] = W3;
      model_mem[i] = mem_arr[i];
    end
    exp_if_rdata = '0; exp_d_rdata = '0; starve_cnt = 0;
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    #1;

    $display("[TB] reset with fetch request pending");
    applyStimulus(1, 1, 4'd1, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    applyStimulus(1, 1, 4'd1, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);

    $display("[TB] back-to-back fetches");
    applyStimulus(0, 1, 4'd1, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    applyStimulus(0, 1, 4'd2, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    applyStimulus(0, 1, 4'd3, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    repeat (3) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    checkOutput("fetch_seq_last", if_rdata, W3);

    $display("[TB] simultaneous fetch and data read");
    applyStimulus(0, 1, 4'd1, 1, 0, 4'd2, 64'd0, 8'd0, ig, dg);
    applyStimulus(0, 1, 4'd1, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    repeat (3) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    checkOutput("d_read_word2", d_rdata, W2);

    $display("[TB] partial write then read");
    applyStimulus(0, 0, 4'd0, 1, 1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, ig, dg);
    applyStimulus(0, 0, 4'd0, 1, 0, 4'd2, 64'd0, 8'd0, ig, dg);
    repeat (3) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    checkOutput("wr_rd_merge", d_rdata, 64'h00200113_FFFFFFFF);

    $display("[TB] reset while fetch in flight");
    applyStimulus(0, 1, 4'd3, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    applyStimulus(1, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    repeat (4) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);

    $display("[TB] data stream against waiting fetch");
    first_gnt = 0; ngnt = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 4'd1, 1, 0, 4'(i), 64'd0, 8'd0, ig, dg);
      if (ig) begin
        ngnt++;
        if (first_gnt == 0) first_gnt = i;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starve_first_gnt", 64'(first_gnt), 64'd5);
`else
    checkOutput("starve_first_gnt", 64'(first_gnt), 64'd0);
    checkOutput("starve_gnt_count", 64'(ngnt), 64'd0);
`endif
    applyStimulus(0, 1, 4'd1, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    repeat (3) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);

    $display("[TB] random traffic");
    fp = 0; dp = 0; dw = 0; fa = '0; da = '0; wd = '0; ws = '0;
    for (int i = 0; i < 400; i++) begin
      if (!fp && ($urandom_range(0, 2) != 0)) begin fp = 1; fa = AW'($urandom); end
      if (!dp && ($urandom_range(0, 1) != 0)) begin
        dp = 1; da = AW'($urandom); dw = 1'($urandom);
        wd = {$urandom, $urandom}; ws = 8'($urandom);
      end
      if ($urandom_range(0, 79) == 0) begin
        applyStimulus(1, fp, fa, dp, dw, da, wd, ws, ig, dg);
      end else begin
        applyStimulus(0, fp, fa, dp, dw, da, wd, ws, ig, dg);
        if (ig) fp = 0;
        if (dg) dp = 0;
      end
    end
    repeat (RL + 2) applyStimulus(0, 0, 4'd0, 0, 0, 4'd0, 64'd0, 8'd0, ig, dg);
    checkOutput("pending_drained", 64'(pend.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported 64-bit instruction/data memory between the fetch stage (read-only) and the load/store unit (read/write).
- Issues at most one memory access per cycle.
- Tracks in-flight reads with an owner tag pipeline and returns each read word, registered, to the requester that issued it.
- Sits between the fetch and mem stages and the unified memory model or SRAM macro.

Parameters:
- ADDR_WIDTH, 4, memory word-address width (each word holds 2 instructions).
- RD_LAT, 1, fixed memory read latency in cycles from mem_re to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 4, consecutive denied fetch cycles before a forced fetch grant (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  64  fetched word
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  64  write data
- d_wstrb  in  8  byte write enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  64  load word
- mem_addr  out  ADDR_WIDTH  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  64  memory write data
- mem_wstrb  out  8  memory byte enables
- mem_rdata  in  64  memory read data, valid RD_LAT cycles after mem_re

Behaviour:
- Reset (async, rst=1): tag pipeline cleared to TAG_NONE; if_rvalid = d_rvalid = 0; if_rdata = d_rdata = 0; starvation counter = 0. Grants and mem strobes are 0 while rst=1, regardless of requests.
- Arbitration (combinational, same cycle):
  - d_req wins over if_req; at most one of if_gnt/d_gnt is high.
  - A requester holds req and address stable until it sees gnt in the same cycle.
  - gnt is never asserted without the matching req.
- Memory outputs follow the winner combinationally:
  - Data read: mem_re = 1.
  - Data write: mem_we = 1, with wdata and wstrb passed through.
  - Fetch: mem_re = 1, mem_wstrb = 0.
  - No winner: mem_re = mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0.
- Tag pipeline:
  - Depth RD_LAT. Stage 0 is loaded with TAG_IF, TAG_D or TAG_NONE each cycle; writes load TAG_NONE.
  - When the last stage holds TAG_IF (TAG_D), mem_rdata is registered into if_rdata (d_rdata) and if_rvalid (d_rvalid) is pulsed for one cycle.
  - Read latency from gnt to rvalid = RD_LAT+1 cycles. Back-to-back grants give back-to-back rvalids in issue order.
- rdata holds its last value when rvalid = 0.
- Write followed by a read of the same address in the next cycle: the memory provides write-first ordering; the arbiter adds no forwarding.
- Reset asserted mid-operation: in-flight reads are dropped with no rvalid for them after reset release.
- Fetch redirect while a read is in flight: the response is still delivered; discarding it is the fetch stage's responsibility.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit saturating counter increments each cycle in which if_req=1 and if_gnt=0.
  - The counter clears on if_gnt or if_req=0.
  - When the counter equals STARVE_MAX, fetch wins that cycle even if d_req=1 (d_gnt=0), and the counter clears.
- Not defined: strict data priority; fetch can starve indefinitely; no counter logic is present.

Decomposition:
- Package rv64_mem_pkg:
  - WORD_W=64, STRB_W=8.
  - Enum resp_tag_t {TAG_NONE, TAG_IF, TAG_D}.
  - RD_LAT_MAX=4.
- Sub-module arb_resp_pipe: RD_LAT-deep resp_tag_t shift register with async reset. Exposes the last-stage tag.

Test Plan (ADDR_WIDTH=4, RD_LAT=1; mem word1 = 64'h00008067_00100093, word2 = 64'h00200113_003081B3):
- Reset for 2 cycles with if_req=1 -> if_gnt=0, mem_re=0, if_rvalid=0, if_rdata=0. After release, first if_gnt next edge; if_rvalid 2 cycles after grant.
- Fetch only, addr 1,2,3 back-to-back -> if_gnt every cycle. if_rdata sequence is 64'h00008067_00100093, then 64'h00200113_003081B3, then word3, on consecutive cycles.
- if_req=1 (addr 1) and d_req=1 d_we=0 (addr 2) in the same cycle -> d_gnt=1, if_gnt=0. d_rdata = 64'h00200113_003081B3 two cycles later. Fetch is granted the following cycle.
- Data write addr 2, wdata 64'hFFFF_FFFF_FFFF_FFFF, wstrb 8'h0F, then read addr 2 -> mem_we one cycle, no d_rvalid for the write. Read returns 64'h00200113_FFFFFFFF.
- Rst asserted one cycle after a fetch grant -> no if_rvalid after release; outputs return to 0 immediately (asynchronous).
- With ARB_STARVE_GUARD_EN: d_req held high for 10 cycles with if_req high -> if_gnt on the 5th cycle (STARVE_MAX=4), d_gnt low that cycle. Without the macro -> if_gnt never asserts.
